// File: rtl/strength_pkg.sv
// Shared strength/level encodings and the per-bit resolution rule used by the
// strength net resolver.
package strength_pkg;

  // Drive strengths, weakest first; HIGHZ means "not driving at all".
  typedef enum logic [2:0] {
    HIGHZ  = 3'd0,
    SMALL  = 3'd1,
    MEDIUM = 3'd2,
    WEAK   = 3'd3,
    LARGE  = 3'd4,
    PULL   = 3'd5,
    STRONG = 3'd6,
    SUPPLY = 3'd7
  } strength_e;

  // 4-state level codes as they appear on out_code.
  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LZ = 2'b10,
    LX = 2'b11
  } lvl_e;

  // Resolved result of one net bit.
  typedef struct packed {
    lvl_e      lvl;
    strength_e str;
  } bit_res_t;

  // Turn the strongest 0-drive and strongest 1-drive into a level and strength.
  // Equal non-zero strengths fight each other and give x at that strength.
  function automatic bit_res_t resolve_bit(input strength_e m0, input strength_e m1);
    bit_res_t r;
    if (m0 == HIGHZ && m1 == HIGHZ) begin
      r.lvl = LZ;
      r.str = HIGHZ;
    end else if (m0 > m1) begin
      r.lvl = L0;
      r.str = m0;
    end else if (m1 > m0) begin
      r.lvl = L1;
      r.str = m1;
    end else begin
      r.lvl = LX;
      r.str = m0;
    end
    return r;
  endfunction

endpackage

// File: rtl/strength_bit_reduce.sv
// Combinational reduction of one net bit: the strongest strength driving a 0
// and the strongest strength driving a 1 across all drivers.
module strength_bit_reduce
  import strength_pkg::*;
#(
  parameter int NDRV = 2
) (
  input  logic [NDRV-1:0]   en,
  input  logic [NDRV-1:0]   bit_val,
  input  logic [NDRV*3-1:0] str0,
  input  logic [NDRV*3-1:0] str1,
  output logic [2:0]        max0,
  output logic [2:0]        max1
);

  // A disabled driver or a HIGHZ contribution never raises either maximum.
  always_comb begin
    max0 = 3'(HIGHZ);
    max1 = 3'(HIGHZ);
    for (int d = 0; d < NDRV; d++) begin
      if (en[d]) begin
        if (!bit_val[d] && (str0[d*3 +: 3] > max0)) begin
          max0 = str0[d*3 +: 3];
        end
        if (bit_val[d] && (str1[d*3 +: 3] > max1)) begin
          max1 = str1[d*3 +: 3];
        end
      end
    end
  end

endmodule

// File: rtl/strength_net_resolver.sv
// Two-stage valid/ready pipeline resolving a multi-driver net into a 4-state
// value and strength per bit, with an expected-pattern match counter and a
// sticky flag for drivers that are enabled but have no usable strength.
module strength_net_resolver
  import strength_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NDRV  = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NDRV-1:0]         in_en,
  input  logic [NDRV*WIDTH-1:0]   in_val,
  input  logic [NDRV*3-1:0]       in_str0,
  input  logic [NDRV*3-1:0]       in_str1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_code,
  output logic [3*WIDTH-1:0]      out_str,
  input  logic                    exp_load,
  input  logic [2*WIDTH-1:0]      exp_code,
  output logic                    match,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    illegal
);

  localparam logic [2*WIDTH-1:0] ALL_Z   = {WIDTH{LZ}};
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic                 adv;
  logic                 xfer;
  logic                 illegal_hit;
  logic [3*WIDTH-1:0]   m0_w, m1_w;
  logic [2*WIDTH-1:0]   code_res;
  logic [3*WIDTH-1:0]   str_res;

  logic                 s1_valid_q, s1_valid_d;
  logic [3*WIDTH-1:0]   s1_m0_q, s1_m0_d;
  logic [3*WIDTH-1:0]   s1_m1_q, s1_m1_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [2*WIDTH-1:0]   code_q, code_d;
  logic [3*WIDTH-1:0]   str_q, str_d;
  logic [2*WIDTH-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;

  // One reducer per bit, fed with that bit of every driver's value.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NDRV-1:0] bit_val;
    for (genvar d = 0; d < NDRV; d++) begin : g_drv
      assign bit_val[d] = in_val[d*WIDTH + b];
    end
    strength_bit_reduce #(.NDRV(NDRV)) u_reduce (
      .en      (in_en),
      .bit_val (bit_val),
      .str0    (in_str0),
      .str1    (in_str1),
      .max0    (m0_w[b*3 +: 3]),
      .max1    (m1_w[b*3 +: 3])
    );
  end

  // Flag any enabled driver whose strengths are both HIGHZ.
  always_comb begin
    illegal_hit = 1'b0;
    for (int d = 0; d < NDRV; d++) begin
      if (in_en[d] && (in_str0[d*3 +: 3] == 3'(HIGHZ)) && (in_str1[d*3 +: 3] == 3'(HIGHZ))) begin
        illegal_hit = 1'b1;
      end
    end
  end

  // Resolve the stage-1 maxima into level/strength for stage 2.
  always_comb begin
    bit_res_t res;
    code_res = '0;
    str_res  = '0;
    res      = '{lvl: LZ, str: HIGHZ};
    for (int b = 0; b < WIDTH; b++) begin
      res = resolve_bit(strength_e'(s1_m0_q[b*3 +: 3]), strength_e'(s1_m1_q[b*3 +: 3]));
      code_res[2*b +: 2] = res.lvl;
      str_res[3*b +: 3]  = res.str;
    end
  end

  assign adv       = !s2_valid_q || out_ready;
  assign xfer      = s2_valid_q && out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid_q;
  assign out_code  = code_q;
  assign out_str   = str_q;
  assign match     = s2_valid_q && (code_q == exp_q);
  assign match_cnt = cnt_q;
  assign illegal   = illegal_q;

  // Next state: the whole pipe shifts together on adv, otherwise everything holds.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_m0_d    = s1_m0_q;
    s1_m1_d    = s1_m1_q;
    s2_valid_d = s2_valid_q;
    code_d     = code_q;
    str_d      = str_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_m0_d = m0_w;
        s1_m1_d = m1_w;
      end
      s2_valid_d = s1_valid_q;
      code_d     = code_res;
      str_d      = str_res;
    end
    if (adv && in_valid && illegal_hit) begin
      illegal_d = 1'b1;
    end
    if (xfer && match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (exp_load) begin
      exp_d = exp_code;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_m0_q    <= '0;
      s1_m1_q    <= '0;
      s2_valid_q <= 1'b0;
      code_q     <= ALL_Z;
      str_q      <= '0;
      exp_q      <= ALL_Z;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_m0_q    <= s1_m0_d;
      s1_m1_q    <= s1_m1_d;
      s2_valid_q <= s2_valid_d;
      code_q     <= code_d;
      str_q      <= str_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_strength_net_resolver.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a behavioural model of the resolver.
module tb_strength_net_resolver;

  localparam int W = 5;
  localparam int N = 2;
  localparam int C = 2;
  localparam int CMAX = (1 << C) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_en;
  logic [N*W-1:0]    in_val;
  logic [N*3-1:0]    in_str0;
  logic [N*3-1:0]    in_str1;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    out_code;
  logic [3*W-1:0]    out_str;
  logic              exp_load;
  logic [2*W-1:0]    exp_code;
  logic              match;
  logic [C-1:0]      match_cnt;
  logic              illegal;

  int checks = 0;
  int errors = 0;

  // Model state: slot 0 is the set just accepted, slot 1 is what the consumer sees.
  logic              m_v[2];
  logic [2*W-1:0]    m_code[2];
  logic [3*W-1:0]    m_str[2];
  logic [2*W-1:0]    m_exp;
  int                m_cnt;
  logic              m_ill;

  strength_net_resolver #(.WIDTH(W), .NDRV(N), .CNT_W(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_en(in_en), .in_val(in_val), .in_str0(in_str0), .in_str1(in_str1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_str(out_str),
    .exp_load(exp_load), .exp_code(exp_code),
    .match(match), .match_cnt(match_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Resolve a driver set straight from the strength rules.
  function automatic void modelResolve(input logic [N-1:0] en, input logic [N*W-1:0] val,
                                       input logic [N*3-1:0] s0, input logic [N*3-1:0] s1,
                                       output logic [2*W-1:0] code, output logic [3*W-1:0] str,
                                       output logic ill);
    ill = 1'b0;
    code = '0;
    str = '0;
    for (int b = 0; b < W; b++) begin
      int m0 = 0;
      int m1 = 0;
      for (int d = 0; d < N; d++) begin
        if (en[d]) begin
          int a0 = int'(s0[d*3 +: 3]);
          int a1 = int'(s1[d*3 +: 3]);
          if (a0 == 0 && a1 == 0) ill = 1'b1;
          else if (val[d*W + b]) m1 = (a1 > m1) ? a1 : m1;
          else m0 = (a0 > m0) ? a0 : m0;
        end
      end
      if (m0 == 0 && m1 == 0) begin code[2*b +: 2] = 2'b10; str[3*b +: 3] = 3'd0; end
      else if (m0 > m1)       begin code[2*b +: 2] = 2'b00; str[3*b +: 3] = 3'(m0); end
      else if (m1 > m0)       begin code[2*b +: 2] = 2'b01; str[3*b +: 3] = 3'(m1); end
      else                    begin code[2*b +: 2] = 2'b11; str[3*b +: 3] = 3'(m0); end
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0;
      m_code[i] = {W{2'b10}};
      m_str[i] = '0;
    end
    m_exp = {W{2'b10}};
    m_cnt = 0;
    m_ill = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void modelStep();
    logic adv;
    logic ill;
    logic [2*W-1:0] c;
    logic [3*W-1:0] s;
    adv = !m_v[1] || out_ready;
    if (m_v[1] && out_ready && (m_code[1] == m_exp) && m_cnt < CMAX) m_cnt++;
    if (adv) begin
      m_v[1] = m_v[0];
      m_code[1] = m_code[0];
      m_str[1] = m_str[0];
      m_v[0] = in_valid;
      if (in_valid) begin
        modelResolve(in_en, in_val, in_str0, in_str1, c, s, ill);
        m_code[0] = c;
        m_str[0] = s;
        if (ill) m_ill = 1'b1;
      end
    end
    if (exp_load) m_exp = exp_code;
  endfunction

  // Every-cycle comparison of the DUT against the model.
  task automatic checkOutput();
    chk("out_valid", 32'(out_valid), 32'(m_v[1]));
    chk("in_ready", 32'(in_ready), 32'(!m_v[1] || out_ready));
    chk("match", 32'(match), 32'(m_v[1] && (m_code[1] == m_exp)));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("illegal", 32'(illegal), 32'(m_ill));
    if (m_v[1] && out_valid) begin
      chk("out_code", 32'(out_code), 32'(m_code[1]));
      chk("out_str", 32'(out_str), 32'(m_str[1]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    checkOutput();
    tick();
  endtask

  task automatic setDrivers(input logic v, input logic [N-1:0] en, input logic [N*W-1:0] val,
                            input logic [N*3-1:0] s0, input logic [N*3-1:0] s1);
    in_valid = v;
    in_en = en;
    in_val = val;
    in_str0 = s0;
    in_str1 = s1;
  endtask

  // Randomized traffic; the expected pattern is sometimes aimed at the next result.
  task automatic applyStimulus();
    logic [31:0] r;
    r = $urandom;
    in_valid = ($urandom_range(0, 3) != 0);
    in_en = r[1:0];
    in_val = r[11:2];
    r = $urandom;
    in_str0 = r[5:0];
    in_str1 = r[11:6];
    out_ready = ($urandom_range(0, 9) < 7);
    exp_load = ($urandom_range(0, 7) == 0);
    exp_code = ($urandom_range(0, 1) == 1) ? m_code[0] : r[21:12];
  endtask

  // Assert reset away from any clock edge and confirm it acts immediately.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'h2AA);
    chk("rst_out_str", 32'(out_str), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    setDrivers(1'b0, '0, '0, '0, '0);
    out_ready = 1'b1;
    exp_load = 1'b0;
    exp_code = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("[TB] directed: single weak driver");
    setDrivers(1'b1, 2'b01, {5'b00000, 5'b10101}, {3'd0, 3'd3}, {3'd0, 3'd0});
    exp_load = 1'b1;
    exp_code = 10'b10_00_10_00_10;
    step();
    setDrivers(1'b0, '0, '0, '0, '0);
    exp_load = 1'b0;
    step();
    #1;
    chk("t1_code", 32'(out_code), 32'b10_00_10_00_10);
    chk("t1_str", 32'(out_str), 32'b000_011_000_011_000);
    chk("t1_match", 32'(match), 32'd1);
    step();
    #1;
    chk("t1_cnt", 32'(match_cnt), 32'd1);
    step();

    $display("[TB] directed: contention");
    setDrivers(1'b1, 2'b11, {5'b00000, 5'b11111}, {3'd6, 3'd5}, {3'd6, 3'd5});
    step();
    setDrivers(1'b1, 2'b11, {5'b00000, 5'b11111}, {3'd6, 3'd5}, {3'd6, 3'd6});
    step();
    setDrivers(1'b0, '0, '0, '0, '0);
    #1;
    chk("t2_code0", 32'(out_code), 32'h000);
    chk("t2_str0", 32'(out_str), 32'b110_110_110_110_110);
    step();
    #1;
    chk("t2_codex", 32'(out_code), 32'h3FF);
    chk("t2_strx", 32'(out_str), 32'b110_110_110_110_110);
    step();

    $display("[TB] directed: stalled stream");
    begin
      int idx = 0;
      for (int c = 0; c < 10; c++) begin
        logic acc;
        out_ready = !(c >= 3 && c <= 5);
        if (idx < 4) setDrivers(1'b1, 2'b01, {5'b0, 5'(idx * 7 + 3)}, {3'd0, 3'd5}, {3'd0, 3'd6});
        else setDrivers(1'b0, '0, '0, '0, '0);
        if (c == 4) begin
          #1;
          chk("t3_stall_ready", 32'(in_ready), 32'd0);
        end
        acc = in_valid && (!m_v[1] || out_ready);
        step();
        if (acc) idx++;
      end
      chk("t3_all_sent", 32'(idx), 32'd4);
    end
    out_ready = 1'b1;

    $display("[TB] directed: illegal driver");
    setDrivers(1'b1, 2'b01, {5'b00000, 5'b11111}, {3'd0, 3'd0}, {3'd0, 3'd0});
    step();
    setDrivers(1'b0, '0, '0, '0, '0);
    step();
    #1;
    chk("t4_code", 32'(out_code), 32'h2AA);
    chk("t4_illegal", 32'(illegal), 32'd1);
    step();

    $display("[TB] directed: counter saturation and same-cycle load");
    doReset();
    exp_code = 10'b10_00_10_00_10;
    exp_load = 1'b1;
    setDrivers(1'b1, 2'b01, {5'b00000, 5'b10101}, {3'd0, 3'd3}, {3'd0, 3'd0});
    step();
    exp_load = 1'b0;
    setDrivers(1'b0, '0, '0, '0, '0);
    step();
    exp_load = 1'b1;
    exp_code = 10'h2AA;
    step();
    exp_load = 1'b0;
    #1;
    chk("t5_oldexp_cnt", 32'(match_cnt), 32'd1);
    exp_code = 10'b10_00_10_00_10;
    exp_load = 1'b1;
    step();
    exp_load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) setDrivers(1'b1, 2'b01, {5'b00000, 5'b10101}, {3'd0, 3'd3}, {3'd0, 3'd0});
      else setDrivers(1'b0, '0, '0, '0, '0);
      if (c >= 3) begin
        #1;
        chk("t5_sat_cnt", 32'(match_cnt), 32'((c - 1 > CMAX) ? CMAX : c - 1));
      end
      step();
    end

    $display("[TB] directed: reset mid-stall");
    out_ready = 1'b0;
    setDrivers(1'b1, 2'b01, {5'b0, 5'b00111}, {3'd0, 3'd4}, {3'd0, 3'd4});
    step();
    setDrivers(1'b1, 2'b01, {5'b0, 5'b11000}, {3'd0, 3'd4}, {3'd0, 3'd4});
    step();
    #1;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    doReset();
    out_ready = 1'b1;
    setDrivers(1'b1, 2'b01, {5'b0, 5'b00001}, {3'd0, 3'd2}, {3'd0, 3'd7});
    step();
    setDrivers(1'b0, '0, '0, '0, '0);
    step();
    #1;
    chk("t6_new_valid", 32'(out_valid), 32'd1);
    chk("t6_new_code", 32'(out_code), 32'b00_00_00_00_01);
    chk("t6_new_str", 32'(out_str), 32'b010_010_010_010_111);
    step();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      applyStimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
